// File: rtl/normalizer_pkg.sv
// Shared types and sizing helpers for the carry-save normalizer.
package normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROP,
    DONE
  } state_t;

  // One guard bit above the input width holds the carry of Cin+Sin.
  function automatic int acc_bit_len(input int in_bit_len);
    return in_bit_len + 1;
  endfunction

  function automatic int pass_cnt_width(input int max_passes);
    return $clog2(max_passes + 1);
  endfunction

endpackage

// File: rtl/norm_column.sv
// One column of the normalizer: loads Cin+Sin, then on each pass keeps its low
// digit and adds the carry handed over from the column below.
module norm_column #(
  parameter int IN_BIT_LEN  = 24,
  parameter int WORD_LEN    = 16,
  parameter int ACC_BIT_LEN = 25
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic                            update,
  input  logic [IN_BIT_LEN-1:0]           cin,
  input  logic [IN_BIT_LEN-1:0]           sin,
  input  logic [ACC_BIT_LEN-WORD_LEN-1:0] carry_in,
  output logic [ACC_BIT_LEN-WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0]             lo
);

  logic [ACC_BIT_LEN-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_BIT_LEN'(cin) + ACC_BIT_LEN'(sin);
    end else if (update) begin
      acc <= ACC_BIT_LEN'(lo) + ACC_BIT_LEN'(carry_in);
    end
  end

  assign hi = acc[ACC_BIT_LEN-1:WORD_LEN];
  assign lo = acc[WORD_LEN-1:0];

endmodule

// File: rtl/carry_save_normalizer.sv
// Resolves per-column carry/sum pairs into WORD_LEN-bit digits plus sticky overflow.
// NORMALIZER_EARLY_EXIT_EN: stop once no column carries; otherwise exactly MAX_PASSES passes.
module carry_save_normalizer
  import normalizer_pkg::*;
#(
  parameter int NUM_COLS   = 66,
  parameter int IN_BIT_LEN = 24,
  parameter int WORD_LEN   = 16,
  parameter int MAX_PASSES = NUM_COLS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0] Cin,
  input  logic [NUM_COLS-1:0][IN_BIT_LEN-1:0] Sin,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_COLS-1:0][WORD_LEN-1:0]   digits,
  output logic                                overflow
);

  localparam int ACC_BIT_LEN = acc_bit_len(IN_BIT_LEN);
  localparam int HI_W        = ACC_BIT_LEN - WORD_LEN;
  localparam int PCW         = pass_cnt_width(MAX_PASSES);

  state_t                        state_q;
  state_t                        state_d;
  logic [PCW-1:0]                pass_cnt;
  logic                          load;
  logic                          update;
  logic                          ovf_force;
  logic [NUM_COLS-1:0][HI_W-1:0] hi;
  logic [NUM_COLS-1:0][HI_W-1:0] carry;

  for (genvar i = 0; i < NUM_COLS; i++) begin : g_col
    if (i == 0) begin : g_lsb
      assign carry[i] = '0;
    end else begin : g_upper
      assign carry[i] = hi[i-1];
    end

    norm_column #(
      .IN_BIT_LEN (IN_BIT_LEN),
      .WORD_LEN   (WORD_LEN),
      .ACC_BIT_LEN(ACC_BIT_LEN)
    ) u_col (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .update  (update),
      .cin     (Cin[i]),
      .sin     (Sin[i]),
      .carry_in(carry[i]),
      .hi      (hi[i]),
      .lo      (digits[i])
    );
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    update    = 1'b0;
    ovf_force = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = PROP;
        end
      end
      PROP: begin
`ifdef NORMALIZER_EARLY_EXIT_EN
        if (~|hi) begin
          state_d = DONE;
        end else if (pass_cnt == PCW'(MAX_PASSES)) begin
          // Pass budget spent with carries still pending: result is not normalized.
          state_d   = DONE;
          ovf_force = 1'b1;
        end else begin
          update = 1'b1;
        end
`else
        if (pass_cnt == PCW'(MAX_PASSES)) begin
          state_d = DONE;
        end else begin
          update = 1'b1;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pass_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        pass_cnt <= '0;
        overflow <= 1'b0;
      end else begin
        if (update) begin
          pass_cnt <= pass_cnt + PCW'(1);
        end
        // Carry out of the top column is dropped; remember that it happened.
        if (ovf_force || (update && (|hi[NUM_COLS-1]))) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_carry_save_normalizer.sv
// Scoreboard bench for carry_save_normalizer: directed vectors, queue-based output checking.
module tb_carry_save_normalizer;

  localparam int NUM_COLS   = 4;
  localparam int IN_BIT_LEN = 19;
  localparam int WORD_LEN   = 16;
  localparam int MAX_PASSES = 4;

  typedef logic [NUM_COLS-1:0][IN_BIT_LEN-1:0] col_t;
  typedef logic [NUM_COLS-1:0][WORD_LEN-1:0]   dig_t;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, overflow;
  col_t cin_v = '0;
  col_t sin_v = '0;
  dig_t digits;

  int tests = 0;
  int fails = 0;

  dig_t q_dig[$];
  logic q_ovf[$];
  int   q_lat[$];

  int   edge_cnt = 0;
  int   acc_edge = 0;
  int   done_cnt = 0;
  int   mon_lat;
  bit   active = 1'b0;
  dig_t cur_dig;
  logic cur_ovf;

  always #5 clk = ~clk;

  carry_save_normalizer #(
    .NUM_COLS  (NUM_COLS),
    .IN_BIT_LEN(IN_BIT_LEN),
    .WORD_LEN  (WORD_LEN),
    .MAX_PASSES(MAX_PASSES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Cin      (cin_v),
    .Sin      (sin_v),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .digits   (digits),
    .overflow (overflow)
  );

  function automatic int lat_of(input int p);
`ifdef NORMALIZER_EARLY_EXIT_EN
    return p + 1;
`else
    return MAX_PASSES + 1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Edge bookkeeping: which clock edge accepted the most recent input.
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_edge = edge_cnt;
    edge_cnt = edge_cnt + 1;
  end

  // Monitor: pops an expectation when out_valid rises, then checks it is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
    end else if (out_valid) begin
      if (!active) begin
        active = 1'b1;
        done_cnt++;
        if (q_dig.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: out_valid with no pending input, digits=0x%0h", digits);
          cur_dig = digits;
          cur_ovf = overflow;
        end else begin
          cur_dig = q_dig.pop_front();
          cur_ovf = q_ovf.pop_front();
          mon_lat = q_lat.pop_front();
          chk("latency", 64'(edge_cnt - 1 - acc_edge), 64'(mon_lat));
          chk("digits", 64'(digits), 64'(cur_dig));
          chk("overflow", 64'(overflow), 64'(cur_ovf));
        end
      end else begin
        chk("hold_digits", 64'(digits), 64'(cur_dig));
        chk("hold_overflow", 64'(overflow), 64'(cur_ovf));
        chk("in_ready_busy", 64'(in_ready), 64'd0);
      end
    end else begin
      active = 1'b0;
    end
  end

  task automatic wait_ready(input string nm);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) timeout(nm);
  endtask

  task automatic issue(input col_t c, input col_t s, input dig_t ed, input logic eo, input int p);
    wait_ready("in_ready");
    cin_v = c;
    sin_v = s;
    in_valid = 1'b1;
    q_dig.push_back(ed);
    q_ovf.push_back(eo);
    q_lat.push_back(lat_of(p));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int g;
    g = 0;
    while (done_cnt < target && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (done_cnt < target) timeout("out_valid");
  endtask

  task automatic send(input col_t c, input col_t s, input dig_t ed, input logic eo, input int p);
    int target;
    target = done_cnt + 1;
    issue(c, s, ed, eo, p);
    wait_done(target);
  endtask

  col_t c, s, rip_c, rip_s;
  dig_t e, rip_e;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_digits", 64'(digits), 64'd0);
    rst_n = 1'b1;

    // Already normalized: no passes needed.
    c = '0; s = '0; s[1] = 19'h1234; s[0] = 19'h5;
    e = '0; e[1] = 16'h1234; e[0] = 16'h5;
    send(c, s, e, 1'b0, 0);

    // Single column carry.
    c = '0; s = '0; s[0] = 19'h10005; c[0] = 19'h3;
    e = '0; e[0] = 16'h8; e[1] = 16'h1;
    send(c, s, e, 1'b0, 1);

    // Carry ripples through two saturated columns.
    rip_c = '0; rip_s = '0; rip_s[2] = 19'hFFFF; rip_s[1] = 19'hFFFF; rip_c[0] = 19'h10000;
    rip_e = '0; rip_e[3] = 16'h1;
    send(rip_c, rip_s, rip_e, 1'b0, 3);

    // Carry out of the top column.
    c = '0; s = '0; s[3] = 19'h10000;
    e = '0;
    send(c, s, e, 1'b1, 1);

    // Normalized input afterwards clears overflow.
    c = '0; s = '0; s[3] = 19'h7; s[1] = 19'hABCD; s[0] = 19'hFFFF;
    e = '0; e[3] = 16'h7; e[1] = 16'hABCD; e[0] = 16'hFFFF;
    send(c, s, e, 1'b0, 0);

    // All-ones inputs in every column: two passes, top carries out.
    c = {NUM_COLS{19'h7FFFF}}; s = {NUM_COLS{19'h7FFFF}};
    e = '0; e[3] = 16'hE; e[2] = 16'hE; e[1] = 16'hD; e[0] = 16'hFFFE;
    send(c, s, e, 1'b1, 2);

    // Backpressure: hold out_ready low while poking in_valid.
    out_ready = 1'b0;
    c = '0; s = '0; s[0] = 19'h10005; c[0] = 19'h3;
    e = '0; e[0] = 16'h8; e[1] = 16'h1;
    send(c, s, e, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cin_v = {NUM_COLS{19'h12345}};
      sin_v = {NUM_COLS{19'h0ABCD}};
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    send(rip_c, rip_s, rip_e, 1'b0, 3);

    // Reset during propagation discards the partial result.
    wait_ready("in_ready_pre_reset");
    cin_v = rip_c;
    sin_v = rip_s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_digits", 64'(digits), 64'd0);
    chk("midrst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_output", 64'(out_valid), 64'd0);
    end

    send(rip_c, rip_s, rip_e, 1'b0, 3);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(q_dig.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
